// File: rtl/clk_div_prog_pkg.sv
// clkdiv_pkg: shared constants, run/stop state and divisor helpers
// used by the programmable clock divider and its bus interface.
package clkdiv_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int FN_W      = 16;
    localparam int FN_W1     = FN_W + 1;

    typedef enum logic {
        STOP,
        RUN
    } state_t;

    // ceil(e/2) = (e>>1) + e[0]
    function automatic logic [FN_W:0] half_of(input logic [FN_W:0] e);
        return (e >> 1) + {{FN_W{1'b0}}, e[0]};
    endfunction

    // Divide-by-1 cannot produce a two-phase output, so it runs as /2.
    function automatic logic [FN_W-1:0] eff_div(input logic [FN_W-1:0] a);
        return (a == FN_W'(1)) ? FN_W'(2) : a;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Divisor control bus: en, div_i, div_load from the master,
// div_busy (pending divisor not yet applied) from the divider.
interface clk_div_prog_if
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             en;
    logic [DIV_W-1:0] div_i;
    logic             div_load;
    logic             div_busy;

    modport master (
        output en,
        output div_i,
        output div_load,
        input  div_busy
    );

    modport slave (
        input  en,
        input  div_i,
        input  div_load,
        output div_busy
    );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer divider with glitch-free
// divisor updates at period boundaries.
// Ports: clk, rst (sync, active-low), bus (slave: en, div_i, div_load,
// div_busy), clk_o (registered divided clock), tick_o (period strobe).
// Macro CLKDIV_TICK_EN: when undefined tick_o is tied to 0.
module clk_div_prog
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus,
    output logic           clk_o,
    output logic           tick_o
);

    localparam int W1 = DIV_W + 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;

    logic [DIV_W-1:0] e_div;
    logic [W1-1:0]    h_len;
    logic [W1-1:0]    cnt_inc;
    logic             at_end;
    state_t           st;

    assign e_div   = DIV_W'(eff_div(FN_W'(act_div_q)));
    assign h_len   = W1'(half_of(FN_W1'(e_div)));
    assign cnt_inc = W1'(cnt_q) + W1'(1);
    assign at_end  = (cnt_q == e_div - DIV_W'(1));
    assign st      = (bus.en && act_div_q != '0) ? RUN : STOP;

    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        clk_d      = clk_q;
        unique case (st)
            RUN: begin
                if (at_end) begin
                    cnt_d = '0;
                    clk_d = 1'b1;
                    if (pend_vld_q) begin
                        act_div_d  = pend_div_q;
                        pend_vld_d = 1'b0;
                    end
                end else begin
                    cnt_d = DIV_W'(cnt_inc);
                    clk_d = (cnt_inc < h_len);
                end
            end
            STOP: begin
                cnt_d = '0;
                clk_d = 1'b1;
                // A stopped divider is always at a boundary.
                if (act_div_q == '0 && pend_vld_q) begin
                    act_div_d  = pend_div_q;
                    pend_vld_d = 1'b0;
                end
            end
            default: ;
        endcase
        // Load after apply: a same-cycle load stays pending.
        if (bus.div_load) begin
            pend_div_d = bus.div_i;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            act_div_q  <= DIV_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
        end
    end

    assign clk_o        = clk_q;
    assign bus.div_busy = pend_vld_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q, tick_d;

    assign tick_d = (st == RUN) && at_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
`else
    assign tick_o = 1'b0;
`endif

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider, the successor to the fixed divide-by-2 toggler.
- Generates a divided clock-like output `clk_o` of period D input cycles, where D is a programmable divisor.
- Also generates a one-cycle `tick_o` strobe.
- Used to derive peripheral and slow-logic enables from the core clock.
- Divisor changes are glitch-free: they take effect only at a period boundary.

Parameters:
- DIV_W, 8, width of the divisor and counter in bits (2..16).
- DEFAULT_DIV, 2, divisor loaded at reset (0 or 2..2^DIV_W-1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset), sampled on rising `clk`.
- en  input  1  run enable; 0 freezes the divider in its idle phase.
- div_i  input  DIV_W  new divisor value, valid when `div_load`=1.
- div_load  input  1  one-cycle request to load `div_i`.
- div_busy  output  1  a loaded divisor is pending and not yet applied.
- clk_o  output  1  divided output, registered.
- tick_o  output  1  one-cycle strobe, coincident with each `clk_o` rising phase start (see optional feature).

Behaviour:
- State registers:
  - `cnt` [DIV_W]
  - `act_div` [DIV_W]
  - `pend_div` [DIV_W]
  - `pend_vld`
  - `clk_o`
  - `tick_o`
- Reset (`rst`=0 at a rising edge):
  - `cnt`=0, `act_div`=DEFAULT_DIV, `pend_vld`=0, `pend_div`=0.
  - `clk_o`=1, `tick_o`=0.
  - Reset has priority over all inputs and aborts any pending load.
- `div_busy` = `pend_vld` (combinational from the register).
- Effective divisor: E = `act_div`, except `act_div`=1 is treated as E=2; `act_div`=0 means STOP.
- High phase H = ceil(E/2) = (E>>1)+E[0]; low phase = E-H.
- State RUN (`en`=1 and `act_div`≠0):
  - Boundary when `cnt`==E-1: `cnt`<=0, `clk_o`<=1, `tick_o`<=1. If `pend_vld` then `act_div`<=`pend_div` and `pend_vld`<=0.
  - Otherwise: `cnt`<=`cnt`+1, `clk_o`<=(`cnt`+1 < H), `tick_o`<=0.
- State STOP (`act_div`=0 or `en`=0):
  - `cnt`<=0, `clk_o`<=1, `tick_o`<=0.
  - Every cycle counts as a boundary, so a pending divisor is applied immediately when `act_div`=0.
  - With `en`=0 the pending divisor is held until `en`=1 and the next RUN boundary.
- `en` 1->0 mid-period: aborts at the next edge (`clk_o`=1, `cnt`=0).
- `en` 0->1: the first RUN cycle counts from `cnt`=0. `clk_o` stays 1 for H cycles total, including the idle cycle, and `tick_o` does not fire until the first boundary.
- Load handshake:
  - `div_load`=1 captures `pend_div`<=`div_i`, `pend_vld`<=1.
  - A load while `pend_vld`=1 overwrites the pending value (last wins).
  - A load on a boundary cycle is captured and applied at the *next* boundary, never the current one.
  - Load and apply in the same cycle: the apply uses the old `pend_div`, and the new value stays pending.
- Arithmetic:
  - `cnt`+1 and the H compare are done at DIV_W+1 bits; no overflow.
  - DIV_W-bit max divisor is 2^DIV_W-1.
- Output timing: `clk_o` and `tick_o` are registered, with no combinational path from inputs.
- Example, E=3 after leaving reset:
  - From the first RUN edge, `clk_o` = 1,0,1,1,0,1,1,0…
  - The first period is 1 high (H−1), 1 low, because the reset cycle itself counts as part of the high phase.
  - Steady state is 2 high, 1 low.

Optional Feature:
- Macro: CLKDIV_TICK_EN.
- Defined: `tick_o` behaves as above.
- Undefined: the `tick_o` register is removed and `tick_o` is tied to 0. The port list is unchanged.

Decomposition:
- Shared package `clkdiv_pkg`:
  - DIV_W default constant.
  - Function `half_of(E)` returning ceil(E/2).
  - Function `eff_div(act)` applying the 1->2 clamp.
  - State enum {STOP, RUN}.
- No sub-module. The pending-divisor shadow register is small enough to stay inline.

Test Plan:
- Reset/default: hold `rst`=0 for 3 cycles, DEFAULT_DIV=2 -> `clk_o`=1 and `tick_o`=0 during reset. After release with `en`=1, `clk_o` toggles every cycle and `tick_o` pulses every 2 cycles.
- Odd divisor: load 5, `en`=1 -> after the boundary, `clk_o` is 3 high / 2 low repeating, one `tick_o` per 5 cycles, and `div_busy` high until that boundary.
- Glitch-free change: running at 8, load 3 at `cnt`=2 -> the current 8-cycle period completes intact (4 high / 4 low), then 2 high / 1 low; `div_busy` drops on the boundary edge.
- Overwrite and same-cycle: load 6 then load 4 on the next cycle -> only 4 is applied. A load of 7 on the boundary cycle while 4 is pending -> 4 is applied now and 7 at the following boundary.
- Stop and clamp: load 0 -> `clk_o` held 1 and no ticks. Then load 1 -> applied on the next edge (STOP boundary) and clamps to divide-by-2, so `clk_o` alternates.
- Enable/reset mid-period: at divisor 10, drop `en` at `cnt`=7 -> next edge `clk_o`=1, `cnt`=0. Re-enable -> the full 5/5 pattern restarts. Assert `rst`=0 with `pend_vld`=1 -> pending value discarded and `act_div`=DEFAULT_DIV.
